// File: rtl/pipeline_scoreboard.sv
// Hazard/bypass controller for the in-order integer pipeline: tracks each issued
// instruction through STAGES post-decode stages and derives stall, bypass and write-back.
module pipeline_scoreboard #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned AW     = 5,
  parameter int unsigned SW     = $clog2(STAGES),
  parameter int unsigned BW     = $clog2(STAGES + 1),
  parameter int unsigned CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec_valid,
  input  logic          dec_kill,
  input  logic          cmiss_stall,
  input  logic [AW-1:0] dec_rs1_addr,
  input  logic          dec_rs1_oen,
  input  logic [AW-1:0] dec_rs2_addr,
  input  logic          dec_rs2_oen,
  input  logic [AW-1:0] dec_wb_addr,
  input  logic          dec_rf_wen,
  input  logic [SW-1:0] dec_ready_stage,
  input  logic          dec_is_csr,
  output logic          dec_stall,
  output logic [BW-1:0] rs1_byp_sel,
  output logic [BW-1:0] rs2_byp_sel,
  output logic          wb_wen,
  output logic [AW-1:0] wb_addr,
  output logic          busy,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic          rf_wen;
    logic [AW-1:0] wbaddr;
    logic [SW-1:0] ready_stage;
    logic          is_csr;
  } stage_t;

  stage_t        stg [STAGES];
  stage_t        dec_entry;
  logic [SW-1:0] rdy_clamped;
  logic          any_valid;
  logic          ser_haz;
  logic          rs1_haz;
  logic          rs2_haz;

  // Youngest (lowest-index) matching writer wins; it bypasses only once its
  // result-ready stage has been reached, otherwise the operand is a hazard.
  function automatic void resolve(input  logic [AW-1:0] addr,
                                  input  logic          oen,
                                  output logic [BW-1:0] sel,
                                  output logic          haz);
    logic          found;
    logic [SW-1:0] k;
    found = 1'b0;
    k     = '0;
    sel   = '0;
    haz   = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (!found && stg[i].valid && stg[i].rf_wen && (stg[i].wbaddr == addr)) begin
        found = 1'b1;
        k     = SW'(i);
      end
    end
    if (found && oen && (addr != '0)) begin
      if (k >= stg[k].ready_stage) sel = BW'(k) + BW'(1);
      else                         haz = 1'b1;
    end
  endfunction

  always_comb begin
    any_valid = 1'b0;
    ser_haz   = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      any_valid = any_valid | stg[i].valid;
      ser_haz   = ser_haz | (stg[i].valid & stg[i].is_csr);
    end
    ser_haz = ser_haz | (dec_is_csr & any_valid);

    resolve(dec_rs1_addr, dec_rs1_oen, rs1_byp_sel, rs1_haz);
    resolve(dec_rs2_addr, dec_rs2_oen, rs2_byp_sel, rs2_haz);

    busy      = any_valid;
    dec_stall = dec_valid & ~dec_kill & (rs1_haz | rs2_haz | ser_haz);

    wb_wen  = stg[STAGES-1].valid & stg[STAGES-1].rf_wen & ~cmiss_stall
            & (stg[STAGES-1].wbaddr != '0);
    wb_addr = wb_wen ? stg[STAGES-1].wbaddr : '0;
  end

  always_comb begin
    rdy_clamped = (dec_ready_stage > SW'(STAGES - 1)) ? SW'(STAGES - 1) : dec_ready_stage;
    dec_entry.valid       = dec_valid & ~dec_kill & ~dec_stall;
    dec_entry.rf_wen      = dec_rf_wen;
    dec_entry.wbaddr      = dec_wb_addr;
    dec_entry.ready_stage = rdy_clamped;
    dec_entry.is_csr      = dec_is_csr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < STAGES; i++) stg[i] <= '0;
      stall_cnt <= '0;
    end else if (!cmiss_stall) begin
      for (int unsigned i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      stg[0] <= dec_entry;
      if (dec_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model of the pipeline.
module tb_pipeline_scoreboard;
  localparam int S  = 4;
  localparam int AW = 5;
  localparam int SW = $clog2(S);
  localparam int BW = $clog2(S + 1);
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_valid, dec_kill, cmiss_stall;
  logic [AW-1:0] dec_rs1_addr, dec_rs2_addr, dec_wb_addr;
  logic          dec_rs1_oen, dec_rs2_oen, dec_rf_wen, dec_is_csr;
  logic [SW-1:0] dec_ready_stage;
  logic          dec_stall, wb_wen, busy;
  logic [BW-1:0] rs1_byp_sel, rs2_byp_sel;
  logic [AW-1:0] wb_addr;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_scoreboard #(.STAGES(S), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_kill(dec_kill),
    .cmiss_stall(cmiss_stall), .dec_rs1_addr(dec_rs1_addr), .dec_rs1_oen(dec_rs1_oen),
    .dec_rs2_addr(dec_rs2_addr), .dec_rs2_oen(dec_rs2_oen), .dec_wb_addr(dec_wb_addr),
    .dec_rf_wen(dec_rf_wen), .dec_ready_stage(dec_ready_stage), .dec_is_csr(dec_is_csr),
    .dec_stall(dec_stall), .rs1_byp_sel(rs1_byp_sel), .rs2_byp_sel(rs2_byp_sel),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .busy(busy), .stall_cnt(stall_cnt)
  );

  // Model: queue of in-flight instructions, index 0 = youngest (EXE).
  typedef struct {
    bit v;
    bit w;
    int addr;
    int rdy;
    bit csr;
  } ent_t;

  ent_t pq[$];
  int   e_sel1, e_sel2, e_waddr, e_cnt;
  bit   e_stall, e_wen, e_busy;

  function automatic void model_clear();
    ent_t z;
    z.v = 0; z.w = 0; z.addr = 0; z.rdy = 0; z.csr = 0;
    pq.delete();
    for (int i = 0; i < S; i++) pq.push_back(z);
    e_cnt = 0;
  endfunction

  function automatic void operand(input int a, input bit oen, output int sel, output bit haz);
    int k;
    k = -1; sel = 0; haz = 0;
    if (oen && a != 0)
      for (int i = 0; i < S; i++)
        if (k < 0 && pq[i].v && pq[i].w && pq[i].addr == a) k = i;
    if (k >= 0) begin
      if (k >= pq[k].rdy) sel = k + 1;
      else haz = 1;
    end
  endfunction

  function automatic void model_eval();
    bit ser, h1, h2;
    e_busy = 0; ser = 0;
    for (int i = 0; i < S; i++) begin
      if (pq[i].v) e_busy = 1;
      if (pq[i].v && pq[i].csr) ser = 1;
    end
    if (dec_is_csr && e_busy) ser = 1;
    operand(int'(dec_rs1_addr), dec_rs1_oen, e_sel1, h1);
    operand(int'(dec_rs2_addr), dec_rs2_oen, e_sel2, h2);
    e_stall = dec_valid && !dec_kill && (h1 || h2 || ser);
    e_wen   = pq[S-1].v && pq[S-1].w && !cmiss_stall && pq[S-1].addr != 0;
    e_waddr = e_wen ? pq[S-1].addr : 0;
  endfunction

  task automatic tick();
    ent_t n;
    model_eval();
    @(posedge clk);
    if (reset && !cmiss_stall) begin
      if (e_stall && e_cnt < CMAX) e_cnt++;
      n.v    = dec_valid && !dec_kill && !e_stall;
      n.w    = dec_rf_wen;
      n.addr = int'(dec_wb_addr);
      n.rdy  = (int'(dec_ready_stage) > S - 1) ? S - 1 : int'(dec_ready_stage);
      n.csr  = dec_is_csr;
      pq.push_front(n);
      void'(pq.pop_back());
    end
    #1;
  endtask

  task automatic set_dec(input bit v, input bit k, input int r1, input bit o1, input int r2,
                         input bit o2, input int wa, input bit wen, input int rdy, input bit csr);
    dec_valid = v; dec_kill = k;
    dec_rs1_addr = AW'(r1); dec_rs1_oen = o1;
    dec_rs2_addr = AW'(r2); dec_rs2_oen = o2;
    dec_wb_addr = AW'(wa); dec_rf_wen = wen;
    dec_ready_stage = SW'(rdy); dec_is_csr = csr;
  endtask

  task automatic idle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmiss_stall = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    model_clear();
    #12;
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_reset();
    reset = 0;
    idle();
    model_clear();
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", dec_stall); end
    checks++; if (stall_cnt !== 0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    reset = 1;
    idle();
    #1;
    checks++; if (busy !== 1'b0 || wb_wen !== 1'b0) begin failures++; $display("FAIL rel_outs got busy=%0d wen=%0d exp=0", busy, wb_wen); end
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) begin
      set_dec(1, 0, 0, 0, 0, 0, i, 1, 0, 0);
      tick();
    end
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checks++; if (stall_cnt !== 1) begin failures++; $display("FAIL mid_cnt_pre got=%0d exp=1", stall_cnt); end
    checks++; if (wb_wen !== 1'b1 || wb_addr !== 1) begin failures++; $display("FAIL mid_wb_pre got wen=%0d addr=%0d exp 1/1", wb_wen, wb_addr); end
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL mid_stall_pre got=%0d exp=1", dec_stall); end
    #2;
    reset = 0;
    model_clear();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0d exp=0", busy); end
    checks++; if (wb_wen !== 1'b0) begin failures++; $display("FAIL mid_wen got=%0d exp=0", wb_wen); end
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL mid_stall got=%0d exp=0", dec_stall); end
    checks++; if (stall_cnt !== 0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    reset = 1;
    set_dec(1, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rel2_busy got=%0d exp=0", busy); end
    @(posedge clk); #1;
    set_dec(1, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (rs1_byp_sel !== 1) begin failures++; $display("FAIL rel2_stage0 got=%0d exp=1", rs1_byp_sel); end
    pq[0].v = 1; pq[0].w = 1; pq[0].addr = 4; pq[0].rdy = 0; pq[0].csr = 0;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    set_dec(1, 0, 5, 1, 0, 0, 6, 1, 0, 0);
    #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", dec_stall); end
    checks++; if (rs1_byp_sel !== 0) begin failures++; $display("FAIL lu_sel_stall got=%0d exp=0", rs1_byp_sel); end
    tick();
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL lu_stall2 got=%0d exp=0", dec_stall); end
    checks++; if (rs1_byp_sel !== 2) begin failures++; $display("FAIL lu_sel got=%0d exp=2", rs1_byp_sel); end
    tick();
    checks++; if (stall_cnt !== 1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_alu_priority();
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    set_dec(1, 0, 0, 0, 0, 0, 7, 1, 0, 0); tick();
    set_dec(1, 0, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    set_dec(1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    #1;
    checks++; if (rs2_byp_sel !== 1) begin failures++; $display("FAIL prio_sel got=%0d exp=1", rs2_byp_sel); end
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL prio_stall got=%0d exp=0", dec_stall); end
    tick();
    idle();
    #1;
    checks++; if (wb_wen !== 1'b1 || wb_addr !== 3) begin failures++; $display("FAIL prio_wb got wen=%0d addr=%0d exp 1/3", wb_wen, wb_addr); end
  endtask

  task automatic test_x0();
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    set_dec(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    #1;
    checks++; if (rs1_byp_sel !== 0 || rs2_byp_sel !== 0) begin failures++; $display("FAIL x0_sel got=%0d/%0d exp 0/0", rs1_byp_sel, rs2_byp_sel); end
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%0d exp=0", dec_stall); end
    tick();
    idle(); tick(); tick();
    checks++; if (wb_wen !== 1'b0 || wb_addr !== 0 || busy !== 1'b1) begin failures++; $display("FAIL x0_wb got wen=%0d addr=%0d busy=%0d exp 0/0/1", wb_wen, wb_addr, busy); end
  endtask

  task automatic test_freeze();
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 9, 1, 0, 0); tick();
    idle(); tick(); tick();
    set_dec(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    set_dec(1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (dec_stall !== 1'b1 || wb_wen !== 1'b1 || wb_addr !== 9) begin failures++; $display("FAIL frz_pre got stall=%0d wen=%0d addr=%0d exp 1/1/9", dec_stall, wb_wen, wb_addr); end
    cmiss_stall = 1;
    #1;
    checks++; if (wb_wen !== 1'b0 || wb_addr !== 0) begin failures++; $display("FAIL frz_wen got wen=%0d addr=%0d exp 0/0", wb_wen, wb_addr); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (dec_stall !== 1'b1 || stall_cnt !== 0 || busy !== 1'b1 || wb_wen !== 1'b0) begin failures++; $display("FAIL frz_hold cyc=%0d got stall=%0d cnt=%0d busy=%0d wen=%0d exp 1/0/1/0", i, dec_stall, stall_cnt, busy, wb_wen); end
      tick();
    end
    cmiss_stall = 0;
    #1;
    checks++; if (wb_wen !== 1'b1 || wb_addr !== 9 || dec_stall !== 1'b1) begin failures++; $display("FAIL frz_resume got wen=%0d addr=%0d stall=%0d exp 1/9/1", wb_wen, wb_addr, dec_stall); end
    tick();
    checks++; if (stall_cnt !== 1 || dec_stall !== 1'b0 || rs1_byp_sel !== 2) begin failures++; $display("FAIL frz_after got cnt=%0d stall=%0d sel=%0d exp 1/0/2", stall_cnt, dec_stall, rs1_byp_sel); end
  endtask

  task automatic test_kill_csr();
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    set_dec(1, 1, 5, 1, 0, 0, 6, 1, 0, 0);
    #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL kill_stall got=%0d exp=0", dec_stall); end
    tick();
    set_dec(1, 0, 5, 1, 6, 1, 0, 0, 0, 0);
    #1;
    checks++; if (rs1_byp_sel !== 2 || rs2_byp_sel !== 0 || dec_stall !== 1'b0) begin failures++; $display("FAIL kill_bubble got sel1=%0d sel2=%0d stall=%0d exp 2/0/0", rs1_byp_sel, rs2_byp_sel, dec_stall); end

    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    idle(); tick();
    set_dec(1, 0, 0, 0, 0, 0, 8, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL csr_stall cyc=%0d got=%0d exp=1", i, dec_stall); end
      tick();
    end
    checks++; if (dec_stall !== 1'b0 || busy !== 1'b0 || stall_cnt !== 3) begin failures++; $display("FAIL csr_clear got stall=%0d busy=%0d cnt=%0d exp 0/0/3", dec_stall, busy, stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 80; i++) begin
      #1;
      model_eval();
      checks++; if (stall_cnt !== e_cnt || dec_stall !== e_stall) begin failures++; $display("FAIL sat_track cyc=%0d got cnt=%0d stall=%0d exp %0d/%0d", i, stall_cnt, dec_stall, e_cnt, e_stall); end
      tick();
    end
    checks++; if (stall_cnt !== CMAX) begin failures++; $display("FAIL sat_final got=%0d exp=%0d", stall_cnt, CMAX); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 3) != 0,
              $urandom_range(0, 3), $urandom_range(0, 11) == 0);
      cmiss_stall = $urandom_range(0, 7) == 0;
      #1;
      model_eval();
      checks++; if (dec_stall !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, dec_stall, e_stall); end
      checks++; if (rs1_byp_sel !== e_sel1) begin failures++; $display("FAIL rnd_sel1 cyc=%0d got=%0d exp=%0d", i, rs1_byp_sel, e_sel1); end
      checks++; if (rs2_byp_sel !== e_sel2) begin failures++; $display("FAIL rnd_sel2 cyc=%0d got=%0d exp=%0d", i, rs2_byp_sel, e_sel2); end
      checks++; if (wb_wen !== e_wen || wb_addr !== e_waddr) begin failures++; $display("FAIL rnd_wb cyc=%0d got wen=%0d addr=%0d exp %0d/%0d", i, wb_wen, wb_addr, e_wen, e_waddr); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%0d exp=%0d", i, busy, e_busy); end
      checks++; if (stall_cnt !== e_cnt) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, e_cnt); end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0;
    idle();
    model_clear();
    test_reset();
    test_load_use();
    test_alu_priority();
    test_x0();
    test_freeze();
    test_kill_csr();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
